// File: rtl/clock_pkg.sv
// Shared encodings, limits and BCD helpers for the 24-hour time keeper.
package clock_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_SET_HOUR = 2'd1;
   localparam logic [1:0] ST_SET_MIN  = 2'd2;

   localparam logic [1:0] EDIT_NONE = 2'b00;
   localparam logic [1:0] EDIT_HOUR = 2'b01;
   localparam logic [1:0] EDIT_MIN  = 2'b10;

   localparam int unsigned HOUR_MAX = 23;
   localparam int unsigned MIN_MAX  = 59;

   typedef struct packed {
      logic [1:0] tens;
      logic [3:0] ones;
   } hour_t;

   typedef struct packed {
      logic [2:0] tens;
      logic [3:0] ones;
   } min_t;

   function automatic hour_t hour_inc(hour_t h);
      hour_t r;
      if (h.tens == 2'(HOUR_MAX / 10) && h.ones == 4'(HOUR_MAX % 10)) begin
         r = '0;
      end else if (h.ones == 4'd9) begin
         r.tens = h.tens + 2'd1;
         r.ones = 4'd0;
      end else begin
         r.tens = h.tens;
         r.ones = h.ones + 4'd1;
      end
      return r;
   endfunction

   function automatic logic min_at_max(min_t m);
      return (m.tens == 3'(MIN_MAX / 10)) && (m.ones == 4'(MIN_MAX % 10));
   endfunction

   function automatic min_t min_inc(min_t m);
      min_t r;
      if (min_at_max(m)) begin
         r = '0;
      end else if (m.ones == 4'd9) begin
         r.tens = m.tens + 3'd1;
         r.ones = 4'd0;
      end else begin
         r.tens = m.tens;
         r.ones = m.ones + 4'd1;
      end
      return r;
   endfunction

   function automatic logic [1:0] next_state(logic [1:0] s);
      case (s)
         ST_RUN:      return ST_SET_HOUR;
         ST_SET_HOUR: return ST_SET_MIN;
         default:     return ST_RUN;
      endcase
   endfunction

   function automatic logic [1:0] edit_code(logic [1:0] s);
      case (s)
         ST_SET_HOUR: return EDIT_HOUR;
         ST_SET_MIN:  return EDIT_MIN;
         default:     return EDIT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, millisecond-sampled debounce counter and rising-edge press pulse.
module button_debounce #(
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_ms,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          mismatch;
   logic          accept;

   assign mismatch = sync[1] ^ level;
   assign accept   = tick_ms & mismatch & (cnt == CW'(DEBOUNCE_MS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b00;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_raw};
         press <= accept & sync[1];
         // A sample that agrees with the held level restarts the qualification window.
         if (tick_ms) begin
            if (!mismatch) begin
               cnt <= '0;
            end else if (accept) begin
               cnt   <= '0;
               level <= sync[1];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/time_keeper_24h.sv
// 24-hour BCD clock with mode/increment buttons, debounce and increment auto-repeat.
module time_keeper_24h
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS     = 20,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_MS  = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_min,
   input  logic       tick_ms,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [1:0] hour_tens,
   output logic [3:0] hour_ones,
   output logic [2:0] min_tens,
   output logic [3:0] min_ones,
   output logic       run,
   output logic [1:0] edit_field
);

   localparam int unsigned RW = $clog2(REPEAT_DELAY_MS + REPEAT_RATE_MS + 1);

   logic mode_level, mode_press, inc_level, inc_press;

   button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_ms(tick_ms),
      .btn_raw(btn_mode),
      .level  (mode_level),
      .press  (mode_press)
   );

   button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_inc_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_ms(tick_ms),
      .btn_raw(btn_inc),
      .level  (inc_level),
      .press  (inc_press)
   );

   logic [1:0]    state, state_d;
   hour_t         hour, hour_d;
   min_t          minute, minute_d;
   logic [RW-1:0] rep_cnt, rep_last;
   logic          rep_first, rep_hold, rep_event, inc_event;

   // Repeat is suspended while mode is also held, so a combined press cannot race ahead.
   assign rep_hold  = inc_level & ~mode_level & (state != ST_RUN);
   assign rep_last  = rep_first ? RW'(REPEAT_DELAY_MS - 1) : RW'(REPEAT_RATE_MS - 1);
   assign rep_event = rep_hold & tick_ms & (rep_cnt == rep_last);
   assign inc_event = inc_press | rep_event;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (!rep_hold || inc_press) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (rep_event) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else if (tick_ms) begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end

   always_comb begin
      state_d  = state;
      hour_d   = hour;
      minute_d = minute;
      case (state)
         ST_RUN: begin
            if (tick_min) begin
               minute_d = min_inc(minute);
               if (min_at_max(minute)) hour_d = hour_inc(hour);
            end
         end
         ST_SET_HOUR: if (inc_event && !mode_press) hour_d = hour_inc(hour);
         ST_SET_MIN:  if (inc_event && !mode_press) minute_d = min_inc(minute);
         default:     state_d = ST_RUN;
      endcase
      if (mode_press) state_d = next_state(state);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         hour       <= '0;
         minute     <= '0;
         run        <= 1'b1;
         edit_field <= EDIT_NONE;
      end else begin
         state      <= state_d;
         hour       <= hour_d;
         minute     <= minute_d;
         // Low as soon as set mode is entered, high one clk after returning to RUN.
         run        <= (state == ST_RUN) && (state_d == ST_RUN);
         edit_field <= edit_code(state_d);
      end
   end

   assign hour_tens = hour.tens;
   assign hour_ones = hour.ones;
   assign min_tens  = minute.tens;
   assign min_ones  = minute.ones;

endmodule

// File: tb/tb_time_keeper_24h.sv
// Directed bench for time_keeper_24h: expected displays are queued, then popped and compared.
module tb_time_keeper_24h;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_min = 1'b0;
   logic       tick_ms = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [1:0] hour_tens;
   logic [3:0] hour_ones;
   logic [2:0] min_tens;
   logic [3:0] min_ones;
   logic       run;
   logic [1:0] edit_field;

   time_keeper_24h dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_min  (tick_min),
      .tick_ms   (tick_ms),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .hour_tens (hour_tens),
      .hour_ones (hour_ones),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .run       (run),
      .edit_field(edit_field)
   );

   always #5 clk = ~clk;

   // One millisecond is four clocks.
   int unsigned ms_div = 0;
   always @(posedge clk) begin
      #1;
      tick_ms = (ms_div == 3);
      ms_div  = (ms_div == 3) ? 0 : ms_div + 1;
   end

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   function automatic logic [15:0] pack(int h, int m, logic r, logic [1:0] e);
      return {r, e, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
   endfunction

   task automatic push(string tag, int h, int m, logic r, logic [1:0] e);
      exp_t x;
      x.tag = tag;
      x.val = pack(h, m, r, e);
      sb.push_back(x);
   endtask

   task automatic check_next();
      exp_t        x;
      logic [15:0] obs;
      if (sb.size() == 0) begin
         mismatched++;
         $error("FAIL scoreboard_empty: observed no entry, required one");
         return;
      end
      x   = sb.pop_front();
      obs = {run, edit_field, hour_tens, hour_ones, min_tens, min_ones};
      compared++;
      assert (obs === x.val) else begin
         mismatched++;
         $error("FAIL %s: observed run=%b edit=%b %0d%0d:%0d%0d, expected run=%b edit=%b %0d%0d:%0d%0d",
                x.tag, obs[15], obs[14:13], obs[12:11], obs[10:7], obs[6:4], obs[3:0],
                x.val[15], x.val[14:13], x.val[12:11], x.val[10:7], x.val[6:4], x.val[3:0]);
      end
   endtask

   task automatic wait_ms(int n);
      repeat (n * 4) @(posedge clk);
      #1;
   endtask

   task automatic press_inc(int n);
      repeat (n) begin
         btn_inc = 1'b1;
         wait_ms(23);
         btn_inc = 1'b0;
         wait_ms(23);
      end
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      wait_ms(23);
      btn_mode = 1'b0;
      wait_ms(23);
   endtask

   task automatic pulse_min();
      @(posedge clk);
      #1 tick_min = 1'b1;
      @(posedge clk);
      #1 tick_min = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      push("reset_state", 0, 0, 1'b1, 2'b00);
      check_next();
      rst_n = 1'b1;
      wait_ms(2);

      // Bouncing mode button gives exactly one transition
      repeat (5) begin
         btn_mode = 1'b1;
         wait_ms(1);
         btn_mode = 1'b0;
         wait_ms(1);
      end
      push("bounce_to_set_hour", 0, 0, 1'b0, 2'b01);
      btn_mode = 1'b1;
      wait_ms(25);
      check_next();
      btn_mode = 1'b0;
      wait_ms(25);
      push("bounce_single_step", 0, 0, 1'b0, 2'b01);
      check_next();

      // Preset 23:58
      press_inc(23);
      push("hour_preset_23", 23, 0, 1'b0, 2'b01);
      check_next();
      press_mode();
      push("enter_set_min", 23, 0, 1'b0, 2'b10);
      check_next();
      press_inc(58);
      push("min_preset_58", 23, 58, 1'b0, 2'b10);
      check_next();
      press_mode();
      push("back_to_run", 23, 58, 1'b1, 2'b00);
      check_next();

      // Minute ticks across midnight
      push("tick_2359", 23, 59, 1'b1, 2'b00);
      push("tick_0000", 0, 0, 1'b1, 2'b00);
      pulse_min();
      check_next();
      pulse_min();
      check_next();
      press_inc(1);
      push("run_ignores_inc", 0, 0, 1'b1, 2'b00);
      check_next();

      // Hour setting with wrap
      press_mode();
      press_inc(22);
      push("set_hour_22", 22, 0, 1'b0, 2'b01);
      push("hour_inc_23", 23, 0, 1'b0, 2'b01);
      push("hour_wrap_00", 0, 0, 1'b0, 2'b01);
      push("hour_inc_01", 1, 0, 1'b0, 2'b01);
      check_next();
      for (int i = 0; i < 3; i++) begin
         press_inc(1);
         check_next();
      end

      // Held inc with auto-repeat
      press_mode();
      press_inc(58);
      push("set_min_58", 1, 58, 1'b0, 2'b10);
      check_next();
      push("hold_press_59", 1, 59, 1'b0, 2'b10);
      push("hold_rep1_00", 1, 0, 1'b0, 2'b10);
      push("hold_rep2_01", 1, 1, 1'b0, 2'b10);
      push("hold_rep3_02", 1, 2, 1'b0, 2'b10);
      push("hold_release", 1, 2, 1'b0, 2'b10);
      btn_inc = 1'b1;
      wait_ms(100);
      check_next();
      wait_ms(500);
      check_next();
      wait_ms(200);
      check_next();
      wait_ms(200);
      check_next();
      btn_inc = 1'b0;
      wait_ms(25);
      check_next();

      // tick_min ignored in set mode; mode beats inc
      repeat (3) pulse_min();
      push("set_min_ignores_tick", 1, 2, 1'b0, 2'b10);
      check_next();
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      wait_ms(25);
      push("mode_beats_inc", 1, 2, 1'b1, 2'b00);
      check_next();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      wait_ms(25);

      // Asynchronous reset mid-edit at 13:27
      press_mode();
      press_inc(12);
      press_mode();
      press_inc(25);
      push("edit_13_27", 13, 27, 1'b0, 2'b10);
      check_next();
      btn_mode = 1'b1;
      wait_ms(10);
      @(posedge clk);
      #2 rst_n = 1'b0;
      btn_mode = 1'b0;
      #2;
      push("async_reset", 0, 0, 1'b1, 2'b00);
      check_next();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_ms(30);
      push("no_pending_after_reset", 0, 0, 1'b1, 2'b00);
      check_next();

      if (sb.size() != 0) begin
         mismatched++;
         $error("FAIL scoreboard_leftover: observed %0d entries, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/time_keeper_24h.md
TIME_KEEPER_24H -- requirements
Module: time_keeper_24h

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20: milliseconds a button level must hold stable before it is accepted.
REQ-002 SHALL have parameter REPEAT_DELAY_MS, default 500: hold time on btn_inc before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE_MS, default 200: auto-repeat period while btn_inc stays held.
REQ-004 SHALL have port clk  input  1  system clock, single clock domain.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick_min  input  1  one-clk pulse per minute from the prescaler.
REQ-007 SHALL have port tick_ms  input  1  one-clk pulse per millisecond from the prescaler.
REQ-008 SHALL have port btn_mode  input  1  raw asynchronous push-button, active-high.
REQ-009 SHALL have port btn_inc  input  1  raw asynchronous push-button, active-high.
REQ-010 SHALL have port hour_tens  output  2  BCD hour tens, 0-2.
REQ-011 SHALL have port hour_ones  output  4  BCD hour ones, 0-9.
REQ-012 SHALL have port min_tens  output  3  BCD minute tens, 0-5.
REQ-013 SHALL have port min_ones  output  4  BCD minute ones, 0-9.
REQ-014 SHALL have port run  output  1  high only in RUN; drives the prescaler start input.
REQ-015 SHALL have port edit_field  output  2  00 none, 01 hours, 10 minutes; used by the display for blinking.

Function
REQ-016 SHALL synchronize each button through two flops before any other use.
REQ-017 SHALL change a debounced level only after the synchronized level differs from it on DEBOUNCE_MS consecutive tick_ms pulses; any mismatch-free sample restarts the count.
REQ-018 SHALL generate a one-clk press event on each 0->1 transition of a debounced level.
REQ-019 SHALL implement FSM states RUN, SET_HOUR, SET_MIN; each mode press advances RUN->SET_HOUR->SET_MIN->RUN.
REQ-020 SHALL, in RUN, advance time by one minute one clk after each tick_min pulse and ignore inc events.
REQ-021 SHALL wrap minutes 59->00 with a carry into hours, and hours 23->00; 23:59 + tick_min -> 00:00.
REQ-022 SHALL, in SET_HOUR and SET_MIN, ignore tick_min.
REQ-023 SHALL, in SET_HOUR, increment hours on each inc event, wrapping 23->00 with no carry.
REQ-024 SHALL, in SET_MIN, increment minutes on each inc event, wrapping 59->00 with no carry into hours.
REQ-025 SHALL, with btn_inc debounced-high in a set state, issue a repeat inc event REPEAT_DELAY_MS after the press and then every REPEAT_RATE_MS until release.
REQ-026 SHALL give a mode event priority over an inc event in the same clk; the inc event SHALL be discarded.
REQ-027 SHALL drive run low in SET_HOUR and SET_MIN and high one clk after entering RUN, so the prescaler restarts its minute count from zero on exit from set mode.
REQ-028 SHALL register all outputs; BCD digits SHALL never take values outside their ranges.

Reset
REQ-029 SHALL, on rst_n low, immediately force time to 00:00, state to RUN, run=1, edit_field=00, and clear debounce and repeat counters and debounced levels.
REQ-030 SHALL, on reset asserted mid-edit or mid-debounce, apply no pending events after reset is released.

Structure
REQ-031 SHALL take the state encoding, edit_field codes and limits (HOUR_MAX=23, MIN_MAX=59) from shared package clock_pkg.
REQ-032 SHALL instantiate sub-module button_debounce (synchronizer, debounce counter, press event) twice; auto-repeat SHALL stay in time_keeper_24h.

Verification
REQ-033 SHALL test: preset 23:58, two tick_min pulses -> 23:59, then 00:00.
REQ-034 SHALL test: btn_mode bouncing 5 times within 10 ms, then stable 25 ms -> exactly one transition, RUN->SET_HOUR, run=0, edit_field=01.
REQ-035 SHALL test: SET_HOUR at 22, three clean inc presses -> 23, 00, 01; minutes unchanged.
REQ-036 SHALL test: SET_MIN at 58, btn_inc held 1000 ms -> press, repeats at 500 and 700 ms, then at 900 ms, reaching 59, 00, 01, 02, with hours unchanged.
REQ-037 SHALL test: tick_min pulses during SET_MIN -> no change; mode and inc events in the same clk -> state advances to RUN and the value is unchanged.
REQ-038 SHALL test: rst_n low mid-edit at 13:27 -> 00:00, RUN, run=1, edit_field=00 without a clk edge.
